// File: rtl/mem_lsu.sv
// Memory-access stage: runs loads/stores against data memory over a req/ack handshake.
// Latency: 1 cycle for NONE/misaligned items, 2 + memory wait cycles for accesses.
// Backpressure: in_ready (and stall_o) drop for the whole ACCESS phase; upstream holds its item.
module mem_lsu #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 16,
  parameter int BIG_ENDIAN  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            memop_i,
  input  logic [31:0]           result_i,
  input  logic [31:0]           store_data_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic                  we_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  whilo_i,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [ADDR_W-1:0]     dm_addr,
  output logic [3:0]            dm_be,
  output logic [31:0]           dm_wdata,
  input  logic                  dm_ack,
  input  logic [31:0]           dm_rdata,
  output logic                  out_valid,
  output logic [31:0]           result_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic                  we_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  whilo_o,
  output logic                  stall_o,
  output logic                  align_err_o,
  output logic                  timeout_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  // One spare bit so the counter can represent TIMEOUT_CYC itself.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Item captured at accept time, held for the whole access.
  logic [3:0]              op_q, op_d;
  logic [31:0]             res_q, res_d;
  logic                    st_q, st_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0]   wa_q, wa_d;
  logic                    rwe_q, rwe_d;
  logic [31:0]             hi_q, hi_d;
  logic [31:0]             lo_q, lo_d;
  logic                    whilo_q, whilo_d;

  // Write-back output registers.
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             result_o_q, result_o_d;
  logic [REG_ADDR_W-1:0]   waddr_o_q, waddr_o_d;
  logic                    we_o_q, we_o_d;
  logic [31:0]             hi_o_q, hi_o_d;
  logic [31:0]             lo_o_q, lo_o_d;
  logic                    whilo_o_q, whilo_o_d;
  logic                    align_err_q, align_err_d;
  logic                    timeout_err_q, timeout_err_d;

  // Input-side decode.
  logic                    in_load, in_store, in_byte, in_half, in_word, in_misalign;
  logic [1:0]              in_byte_lane;
  logic                    in_half_sel;
  logic [3:0]              in_be;
  logic [31:0]             in_wdata;

  // Load-side extraction.
  logic [1:0]              ld_byte_lane;
  logic                    ld_half_sel;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [31:0]             ld_val;
  logic                    ld_q;

  logic [CNT_W-1:0]        cnt_inc;
  logic                    timeout_hit;

  // Classify the incoming op and build lane-mapped byte enables and store data.
  always_comb begin
    in_load      = (memop_i >= OP_LB) && (memop_i <= OP_LW);
    in_store     = (memop_i >= OP_SB) && (memop_i <= OP_SW);
    in_byte      = (memop_i == OP_LB) || (memop_i == OP_LBU) || (memop_i == OP_SB);
    in_half      = (memop_i == OP_LH) || (memop_i == OP_LHU) || (memop_i == OP_SH);
    in_word      = (memop_i == OP_LW) || (memop_i == OP_SW);
    in_misalign  = (in_half && result_i[0]) || (in_word && (result_i[1:0] != 2'b00));
    // Big-endian puts byte k on lane 3-k, which is the bitwise inverse of k.
    in_byte_lane = (BIG_ENDIAN != 0) ? ~result_i[1:0] : result_i[1:0];
    in_half_sel  = (BIG_ENDIAN != 0) ? ~result_i[1]   : result_i[1];
    in_be        = 4'hF;
    in_wdata     = 32'd0;
    if (in_store) begin
      if (in_byte) begin
        in_be    = 4'b0001 << in_byte_lane;
        in_wdata = {4{store_data_i[7:0]}};
      end else if (in_half) begin
        in_be    = in_half_sel ? 4'b1100 : 4'b0011;
        in_wdata = {2{store_data_i[15:0]}};
      end else begin
        in_be    = 4'hF;
        in_wdata = store_data_i;
      end
    end
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    ld_byte_lane = (BIG_ENDIAN != 0) ? ~res_q[1:0] : res_q[1:0];
    ld_half_sel  = (BIG_ENDIAN != 0) ? ~res_q[1]   : res_q[1];
    ld_byte      = dm_rdata[{ld_byte_lane, 3'b000} +: 8];
    ld_half      = dm_rdata[{ld_half_sel, 4'b0000} +: 16];
    ld_q         = (op_q >= OP_LB) && (op_q <= OP_LW);
    case (op_q)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'd0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'd0, ld_half};
      default: ld_val = dm_rdata;
    endcase
  end

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // Next-state and output-register logic; ack takes priority over timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    res_d         = res_q;
    st_d          = st_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    wa_d          = wa_q;
    rwe_d         = rwe_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    whilo_d       = whilo_q;
    out_valid_d   = 1'b0;
    result_o_d    = result_o_q;
    waddr_o_d     = waddr_o_q;
    we_o_d        = 1'b0;
    hi_o_d        = hi_o_q;
    lo_o_d        = lo_o_q;
    whilo_o_d     = 1'b0;
    align_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if ((in_load || in_store) && !in_misalign) begin
            state_d = S_ACCESS;
            cnt_d   = '0;
            op_d    = memop_i;
            res_d   = result_i;
            st_d    = in_store;
            be_d    = in_be;
            wdata_d = in_wdata;
            wa_d    = waddr_i;
            rwe_d   = we_i;
            hi_d    = hi_i;
            lo_d    = lo_i;
            whilo_d = whilo_i;
          end else begin
            // NONE or misaligned: complete immediately without touching memory.
            out_valid_d = 1'b1;
            result_o_d  = result_i;
            waddr_o_d   = waddr_i;
            we_o_d      = in_misalign ? 1'b0 : we_i;
            hi_o_d      = hi_i;
            lo_o_d      = lo_i;
            whilo_o_d   = whilo_i;
            align_err_d = in_misalign;
          end
        end
      end
      S_ACCESS: begin
        if (dm_ack || timeout_hit) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          out_valid_d   = 1'b1;
          result_o_d    = (dm_ack && ld_q) ? ld_val : res_q;
          waddr_o_d     = wa_q;
          we_o_d        = dm_ack && ld_q && rwe_q;
          hi_o_d        = hi_q;
          lo_o_d        = lo_q;
          whilo_o_d     = whilo_q;
          timeout_err_d = !dm_ack;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured item and output registers; reset abandons any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      res_q         <= '0;
      st_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      wa_q          <= '0;
      rwe_q         <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      whilo_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      result_o_q    <= '0;
      waddr_o_q     <= '0;
      we_o_q        <= 1'b0;
      hi_o_q        <= '0;
      lo_o_q        <= '0;
      whilo_o_q     <= 1'b0;
      align_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      res_q         <= res_d;
      st_q          <= st_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      wa_q          <= wa_d;
      rwe_q         <= rwe_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      whilo_q       <= whilo_d;
      out_valid_q   <= out_valid_d;
      result_o_q    <= result_o_d;
      waddr_o_q     <= waddr_o_d;
      we_o_q        <= we_o_d;
      hi_o_q        <= hi_o_d;
      lo_o_q        <= lo_o_d;
      whilo_o_q     <= whilo_o_d;
      align_err_q   <= align_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign stall_o       = !in_ready;
  assign dm_req        = (state_q == S_ACCESS);
  assign dm_we         = dm_req && st_q;
  assign dm_addr       = {res_q[ADDR_W-1:2], 2'b00};
  assign dm_be         = be_q;
  assign dm_wdata      = wdata_q;
  assign out_valid     = out_valid_q;
  assign result_o      = result_o_q;
  assign waddr_o       = waddr_o_q;
  assign we_o          = we_o_q;
  assign hi_o          = hi_o_q;
  assign lo_o          = lo_o_q;
  assign whilo_o       = whilo_o_q;
  assign align_err_o   = align_err_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: little-endian (a) and big-endian (b) instances share stimulus.
// Items are checked against a byte-level reference model of loads, stores and lanes.
// Memory ack timing is driven by the bench; timeouts and reset mid-access are exercised.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  memop_i = '0;
  logic [31:0] result_i = '0, store_data_i = '0, hi_i = '0, lo_i = '0;
  logic [4:0]  waddr_i = '0;
  logic        we_i = 1'b0, whilo_i = 1'b0;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;

  logic        in_ready_a, dm_req_a, dm_we_a, out_valid_a, we_o_a, whilo_o_a, stall_a, aerr_a, terr_a;
  logic [31:0] dm_addr_a, dm_wdata_a, result_o_a, hi_o_a, lo_o_a;
  logic [3:0]  dm_be_a;
  logic [4:0]  waddr_o_a;
  logic        in_ready_b, dm_req_b, dm_we_b, out_valid_b, we_o_b, whilo_o_b, stall_b, aerr_b, terr_b;
  logic [31:0] dm_addr_b, dm_wdata_b, result_o_b, hi_o_b, lo_o_b;
  logic [3:0]  dm_be_b;
  logic [4:0]  waddr_o_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(16), .BIG_ENDIAN(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .memop_i(memop_i),
    .result_i(result_i), .store_data_i(store_data_i), .waddr_i(waddr_i), .we_i(we_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .dm_req(dm_req_a), .dm_we(dm_we_a),
    .dm_addr(dm_addr_a), .dm_be(dm_be_a), .dm_wdata(dm_wdata_a), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .out_valid(out_valid_a), .result_o(result_o_a), .waddr_o(waddr_o_a),
    .we_o(we_o_a), .hi_o(hi_o_a), .lo_o(lo_o_a), .whilo_o(whilo_o_a), .stall_o(stall_a),
    .align_err_o(aerr_a), .timeout_err_o(terr_a));

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(16), .BIG_ENDIAN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .memop_i(memop_i),
    .result_i(result_i), .store_data_i(store_data_i), .waddr_i(waddr_i), .we_i(we_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .dm_req(dm_req_b), .dm_we(dm_we_b),
    .dm_addr(dm_addr_b), .dm_be(dm_be_b), .dm_wdata(dm_wdata_b), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .out_valid(out_valid_b), .result_o(result_o_b), .waddr_o(waddr_o_b),
    .we_o(we_o_b), .hi_o(hi_o_b), .lo_o(lo_o_b), .whilo_o(whilo_o_b), .stall_o(stall_b),
    .align_err_o(aerr_b), .timeout_err_o(terr_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  // kind: 0 = no memory op, 1 = misaligned, 2 = load, 3 = store
  function automatic int kind_of(input logic [3:0] op, input logic [31:0] addr);
    bit is_half = (op == 3 || op == 4 || op == 7);
    bit is_word = (op == 5 || op == 8);
    if (op < 1 || op > 8) return 0;
    if ((is_half && addr[0]) || (is_word && addr[1:0] != 0)) return 1;
    return (op <= 5) ? 2 : 3;
  endfunction

  function automatic int lane(input int k, input bit big);
    return big ? 3 - k : k;
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] addr, input bit big);
    int off = int'(addr[1:0]);
    logic [3:0] be = 4'h0;
    if (op == 6) be[lane(off, big)] = 1'b1;
    else if (op == 7) begin
      be[lane(off, big)] = 1'b1;
      be[lane(off + 1, big)] = 1'b1;
    end else be = 4'hF;
    return be;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [3:0] op, input logic [31:0] sd);
    if (op == 6) return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
    if (op == 7) return {sd[15:0], sd[15:0]};
    return sd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd, input bit big);
    logic [7:0] b [4];
    int off = int'(addr[1:0]);
    logic [15:0] h;
    for (int k = 0; k < 4; k++) b[k] = rd[8*lane(k, big) +: 8];
    h = (off < 3) ? (big ? {b[off], b[off+1]} : {b[off+1], b[off]}) : 16'h0;
    case (op)
      4'd1: return {{24{b[off][7]}}, b[off]};
      4'd2: return {24'h0, b[off]};
      4'd3: return {{16{h[15]}}, h};
      4'd4: return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  // Present one item, run the memory side, and check the write-back pulse.
  task automatic do_item(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rd, input logic [4:0] wa, input logic we,
                         input int waits, input bit never_ack);
    int k;
    int n;
    logic [31:0] hv, lv;
    logic wl;
    hv = $urandom;
    lv = $urandom;
    wl = 1'($urandom_range(0, 1));
    k = kind_of(op, addr);
    check("in_ready", in_ready_a, 1);
    memop_i = op; result_i = addr; store_data_i = sd; waddr_i = wa; we_i = we;
    hi_i = hv; lo_i = lv; whilo_i = wl; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (k < 2) begin
      check("imm_valid", out_valid_a, 1);
      check("imm_req", dm_req_a, 0);
      check("imm_aerr", aerr_a, (k == 1));
      check("imm_we", we_o_a, (k == 1) ? 1'b0 : we);
      check("imm_whilo", whilo_o_a, wl);
      check("imm_hi", hi_o_a, hv);
      if (k == 0) begin
        check("imm_res", result_o_a, addr);
        check("imm_waddr", waddr_o_a, wa);
      end
    end else begin
      check("acc_req", dm_req_a, 1);
      check("acc_stall", stall_a, 1);
      check("acc_we", dm_we_a, (k == 3));
      check("acc_addr", dm_addr_a, addr & 32'hFFFF_FFFC);
      check("acc_be_le", dm_be_a, exp_be(op, addr, 1'b0));
      check("acc_be_be", dm_be_b, exp_be(op, addr, 1'b1));
      if (k == 3) check("acc_wd", dm_wdata_a, exp_wd(op, sd));
      if (never_ack) begin
        n = 0;
        while (dm_req_a && n < 40) begin
          n++;
          tick();
        end
        check("to_cycles", n, 16);
        check("to_valid", out_valid_a, 1);
        check("to_err", terr_a, 1);
        check("to_err_b", terr_b, 1);
        check("to_we", we_o_a, 0);
      end else begin
        for (int w = 0; w < waits; w++) begin
          check("wait_valid", out_valid_a, 0);
          check("wait_req", dm_req_a, 1);
          tick();
        end
        dm_ack = 1'b1;
        dm_rdata = rd;
        tick();
        dm_ack = 1'b0;
        dm_rdata = $urandom;
        check("ack_valid", out_valid_a, 1);
        check("ack_req_drop", dm_req_a, 0);
        check("ack_terr", terr_a, 0);
        check("ack_res_le", result_o_a, (k == 2) ? exp_load(op, addr, rd, 1'b0) : addr);
        check("ack_res_be", result_o_b, (k == 2) ? exp_load(op, addr, rd, 1'b1) : addr);
        check("ack_we", we_o_a, (k == 2) ? we : 1'b0);
        check("ack_waddr", waddr_o_a, wa);
        check("ack_whilo", whilo_o_a, wl);
        check("ack_lo", lo_o_a, lv);
      end
    end
    tick();
    check("pulse_end", out_valid_a, 0);
    check("pulse_we", we_o_a, 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    // Reset state
    tick();
    check("rst_ready", in_ready_a, 1);
    check("rst_req", dm_req_a, 0);
    check("rst_valid", out_valid_a, 0);
    check("rst_stall", stall_a, 0);
    check("rst_res", result_o_a, 0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    do_item(4'd0, 32'h1234, 32'h0, 32'h0, 5'd3, 1'b1, 0, 1'b0);          // NONE
    do_item(4'd1, 32'h103, 32'h0, 32'h80AA55CC, 5'd4, 1'b1, 2, 1'b0);    // LB -> FFFFFF80
    do_item(4'd2, 32'h103, 32'h0, 32'h80AA55CC, 5'd4, 1'b1, 2, 1'b0);    // LBU -> 00000080
    do_item(4'd7, 32'h202, 32'hDEADBEEF, 32'h0, 5'd5, 1'b1, 1, 1'b0);    // SH
    do_item(4'd5, 32'h6, 32'h0, 32'h0, 5'd6, 1'b1, 0, 1'b0);             // misaligned LW
    do_item(4'd5, 32'h40, 32'h0, 32'h0, 5'd7, 1'b1, 0, 1'b1);            // timeout
    do_item(4'd3, 32'h42, 32'h0, 32'h8001_7FFE, 5'd8, 1'b1, 15, 1'b0);   // ack on the timeout cycle
    do_item(4'd12, 32'hCAFE, 32'h0, 32'h0, 5'd9, 1'b1, 0, 1'b0);         // op 12 behaves as NONE

    // Ack while idle must be ignored
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("idle_ack_valid", out_valid_a, 0);
    check("idle_ack_req", dm_req_a, 0);

    // Reset in the middle of an access
    memop_i = 4'd5; result_i = 32'h80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_req", dm_req_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", dm_req_a, 0);
    check("mid_rst_valid", out_valid_a, 0);
    check("mid_rst_ready", in_ready_a, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", out_valid_a, 0);
    do_item(4'd0, 32'h55, 32'h0, 32'h0, 5'd1, 1'b1, 0, 1'b0);

    // Randomized items
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      addr = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      do_item(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
              $urandom_range(0, 4), (i % 20) == 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
